// File: rtl/duck_pkg.sv
// Shared constants for the duck sprite scheduler: per-duck state codes,
// sprite frame indices and the default visible raster size.
package duck_pkg;

  localparam logic [1:0] ST_FLY  = 2'd0;
  localparam logic [1:0] ST_HIT  = 2'd1;
  localparam logic [1:0] ST_FALL = 2'd2;
  localparam logic [1:0] ST_GONE = 2'd3;

  localparam logic [1:0] FRM_WING_UP   = 2'd0;
  localparam logic [1:0] FRM_WING_DOWN = 2'd1;
  localparam logic [1:0] FRM_HIT       = 2'd2;
  localparam logic [1:0] FRM_FALL      = 2'd3;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

endpackage

// File: rtl/duck_object.sv
// One duck: FLY/HIT/FALL/GONE life cycle, position and velocity, wing-flap
// counter, and box tests of the current pixel and of the shot position.
module duck_object
  import duck_pkg::*;
#(
  parameter int IDX         = 0,
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int H_ACT       = DEF_H_ACTIVE,
  parameter int V_ACT       = DEF_V_ACTIVE,
  parameter int SPEED       = 2,
  parameter int FALL_SPEED  = 4,
  parameter int HIT_FRAMES  = 30,
  parameter int ANIM_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       round_start,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic [9:0] shot_x,
  input  logic [9:0] shot_y,
  output logic       covers,
  output logic       shootable,
  output logic       gone,
  output logic [1:0] frame,
  output logic [9:0] dx,
  output logic [9:0] dy
);

  localparam logic signed [10:0] X_LIM   = 11'(H_ACT - SPR_W);
  localparam logic signed [10:0] Y_LIM   = 11'(V_ACT - SPR_H);
  localparam logic signed [10:0] X_INIT  = 11'(16 + IDX * 2 * SPR_W);
  localparam logic signed [10:0] Y_INIT  = 11'(64 + IDX * SPR_H);
  localparam logic signed [10:0] V_FLY   = 11'(SPEED);
  localparam logic signed [10:0] V_FALL  = 11'(FALL_SPEED);
  localparam logic signed [10:0] VY_INIT = (IDX % 2 == 0) ? -V_FLY : V_FLY;
  localparam logic [7:0] ANIM_LAST = 8'(ANIM_FRAMES - 1);
  localparam logic [7:0] HIT_LAST  = 8'(HIT_FRAMES - 1);

  logic [1:0]         state_reg, state_next;
  logic signed [10:0] x_reg, x_next, y_reg, y_next;
  logic signed [10:0] vx_reg, vx_next, vy_reg, vy_next;
  logic [7:0]         anim_cnt_reg, anim_cnt_next, hit_cnt_reg, hit_cnt_next;
  logic               anim_bit_reg, anim_bit_next;
  logic signed [10:0] nx, ny, fy;
  logic [11:0]        pdx, pdy, sdx, sdy;

  assign nx = x_reg + vx_reg;
  assign ny = y_reg + vy_reg;
  assign fy = y_reg + V_FALL;

  always_comb begin
    state_next    = state_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    vx_next       = vx_reg;
    vy_next       = vy_reg;
    anim_cnt_next = anim_cnt_reg;
    anim_bit_next = anim_bit_reg;
    hit_cnt_next  = hit_cnt_reg;
    // A shot on the tick cycle freezes this duck for that frame.
    if (hit) begin
      state_next   = ST_HIT;
      hit_cnt_next = 8'd0;
    end else if (frame_tick) begin
      case (state_reg)
        ST_FLY: begin
          if (nx < 11'sd0) begin
            x_next  = 11'sd0;
            vx_next = -vx_reg;
          end else if (nx > X_LIM) begin
            x_next  = X_LIM;
            vx_next = -vx_reg;
          end else begin
            x_next = nx;
          end
          if (ny < 11'sd0) begin
            y_next  = 11'sd0;
            vy_next = -vy_reg;
          end else if (ny > Y_LIM) begin
            y_next  = Y_LIM;
            vy_next = -vy_reg;
          end else begin
            y_next = ny;
          end
          if (anim_cnt_reg == ANIM_LAST) begin
            anim_cnt_next = 8'd0;
            anim_bit_next = ~anim_bit_reg;
          end else begin
            anim_cnt_next = anim_cnt_reg + 8'd1;
          end
        end
        ST_HIT: begin
          if (hit_cnt_reg == HIT_LAST) state_next = ST_FALL;
          else hit_cnt_next = hit_cnt_reg + 8'd1;
        end
        ST_FALL: begin
          if (fy >= Y_LIM) begin
            y_next     = Y_LIM;
            state_next = ST_GONE;
          end else begin
            y_next = fy;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || round_start) begin
      state_reg    <= ST_FLY;
      x_reg        <= X_INIT;
      y_reg        <= Y_INIT;
      vx_reg       <= V_FLY;
      vy_reg       <= VY_INIT;
      anim_cnt_reg <= 8'd0;
      anim_bit_reg <= 1'b0;
      hit_cnt_reg  <= 8'd0;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      vx_reg       <= vx_next;
      vy_reg       <= vy_next;
      anim_cnt_reg <= anim_cnt_next;
      anim_bit_reg <= anim_bit_next;
      hit_cnt_reg  <= hit_cnt_next;
    end
  end

  // Offsets are 12-bit two's complement; bit 11 flags "left of / above" the box.
  assign pdx = {2'b00, hcount} - {x_reg[10], x_reg};
  assign pdy = {2'b00, vcount} - {y_reg[10], y_reg};
  assign sdx = {2'b00, shot_x} - {x_reg[10], x_reg};
  assign sdy = {2'b00, shot_y} - {y_reg[10], y_reg};

  assign gone      = (state_reg == ST_GONE);
  assign covers    = !gone && !pdx[11] && (pdx[10:0] < 11'(SPR_W))
                           && !pdy[11] && (pdy[10:0] < 11'(SPR_H));
  assign shootable = (state_reg == ST_FLY) && !sdx[11] && (sdx[10:0] < 11'(SPR_W))
                           && !sdy[11] && (sdy[10:0] < 11'(SPR_H));
  assign dx = pdx[9:0];
  assign dy = pdy[9:0];

  always_comb begin
    case (state_reg)
      ST_FLY:  frame = anim_bit_reg ? FRM_WING_DOWN : FRM_WING_UP;
      ST_HIT:  frame = FRM_HIT;
      default: frame = FRM_FALL;
    endcase
  end

endmodule

// File: rtl/duck_sprite_scheduler.sv
// Owns NUM_SPRITES ducks, arbitrates the shared sprite ROM per pixel and
// resolves shots; lower duck index wins both the pixel and the shot.
module duck_sprite_scheduler
  import duck_pkg::*;
#(
  parameter int         NUM_SPRITES = 4,
  parameter int         SPR_W       = 32,
  parameter int         SPR_H       = 32,
  parameter int         H_ACTIVE    = DEF_H_ACTIVE,
  parameter int         V_ACTIVE    = DEF_V_ACTIVE,
  parameter int         SPEED       = 2,
  parameter int         FALL_SPEED  = 4,
  parameter int         HIT_FRAMES  = 30,
  parameter int         ANIM_FRAMES = 8,
  parameter logic [5:0] TRANSP      = 6'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic [5:0]  rom_data,
  input  logic        round_start,
  input  logic        shot_valid,
  input  logic [9:0]  shot_x,
  input  logic [9:0]  shot_y,
  output logic [14:0] rom_addr,
  output logic        draw,
  output logic [2:0]  sprite_id,
  output logic        shot_hit,
  output logic [2:0]  hit_id,
  output logic        all_gone
);

  logic                   frame_tick;
  logic [NUM_SPRITES-1:0] covers, shootable, gone, hit_onehot;
  logic [1:0]             frame [NUM_SPRITES];
  logic [9:0]             dx [NUM_SPRITES];
  logic [9:0]             dy [NUM_SPRITES];

  logic        hit_any, pix_any;
  logic [2:0]  hit_idx, pix_idx;
  logic [1:0]  sel_frame;
  logic [9:0]  sel_dx, sel_dy;
  logic [14:0] addr_next;

  logic [14:0] rom_addr_reg;
  logic        draw_q_reg, shot_hit_reg, all_gone_reg;
  logic [2:0]  sprite_id_reg, hit_id_reg;

  assign frame_tick = (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));

  generate
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_duck
      duck_object #(
        .IDX(gi), .SPR_W(SPR_W), .SPR_H(SPR_H), .H_ACT(H_ACTIVE), .V_ACT(V_ACTIVE),
        .SPEED(SPEED), .FALL_SPEED(FALL_SPEED), .HIT_FRAMES(HIT_FRAMES),
        .ANIM_FRAMES(ANIM_FRAMES)
      ) u_duck (
        .clk(clk), .reset(reset), .round_start(round_start), .frame_tick(frame_tick),
        .hit(hit_onehot[gi]), .hcount(hcount), .vcount(vcount),
        .shot_x(shot_x), .shot_y(shot_y),
        .covers(covers[gi]), .shootable(shootable[gi]), .gone(gone[gi]),
        .frame(frame[gi]), .dx(dx[gi]), .dy(dy[gi])
      );
    end
  endgenerate

  // Scan from the top index down so the lowest matching index is left standing.
  always_comb begin
    hit_onehot = '0;
    hit_any    = 1'b0;
    hit_idx    = 3'd0;
    pix_any    = 1'b0;
    pix_idx    = 3'd0;
    sel_frame  = 2'd0;
    sel_dx     = 10'd0;
    sel_dy     = 10'd0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (shot_valid && shootable[i]) begin
        hit_onehot    = '0;
        hit_onehot[i] = 1'b1;
        hit_any       = 1'b1;
        hit_idx       = 3'(i);
      end
      if (covers[i]) begin
        pix_any   = 1'b1;
        pix_idx   = 3'(i);
        sel_frame = frame[i];
        sel_dx    = dx[i];
        sel_dy    = dy[i];
      end
    end
  end

  assign addr_next = 15'(sel_frame) * 15'(SPR_W * SPR_H)
                   + 15'(sel_dy) * 15'(SPR_W) + 15'(sel_dx);

  always_ff @(posedge clk) begin
    if (reset || round_start) begin
      rom_addr_reg  <= 15'd0;
      draw_q_reg    <= 1'b0;
      sprite_id_reg <= 3'd0;
      shot_hit_reg  <= 1'b0;
      hit_id_reg    <= 3'd0;
      all_gone_reg  <= 1'b0;
    end else begin
      draw_q_reg   <= pix_any;
      shot_hit_reg <= hit_any;
      all_gone_reg <= &gone;
      if (pix_any) begin
        rom_addr_reg  <= addr_next;
        sprite_id_reg <= pix_idx;
      end
      if (hit_any) hit_id_reg <= hit_idx;
    end
  end

  assign rom_addr  = rom_addr_reg;
  assign draw      = draw_q_reg && (rom_data != TRANSP);
  assign sprite_id = sprite_id_reg;
  assign shot_hit  = shot_hit_reg;
  assign hit_id    = hit_id_reg;
  assign all_gone  = all_gone_reg;

endmodule
